// File: rtl/k005297_pkg.sv
// Shared types and constants for the K005297 subclock-stop scheduler slice.
package k005297_pkg;

  localparam int ROT20_LEN    = 20;
  localparam int ROT8_LEN     = 8;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STOPPING,
    ST_GRANTED,
    ST_RELEASE
  } sched_state_t;

endpackage

// File: rtl/k005297_subclk_sched_if.sv
// Requester-side handshake of the subclock-stop scheduler: level requests in, one-hot grant out.
interface k005297_subclk_sched_if
  import k005297_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            timeout;

  modport master (output req, input gnt, input busy, input timeout);
  modport slave  (input req, output gnt, output busy, output timeout);

endinterface

// File: rtl/k005297_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module k005297_rr_pick
  import k005297_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns idx/valid and no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (!valid && req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/k005297_subclk_sched.sv
// Subclock-stop scheduler: round-robin arbitration, slot-aligned stop request, grant and hold watchdog.
module k005297_subclk_sched
  import k005297_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int SLOT_IDX = 19,
  parameter int HOLD_MAX = 64
) (
  input  logic                 i_MCLK,
  input  logic                 i_MRST,
  input  logic                 i_CLK4M_PCEN_n,
  input  logic [ROT8_LEN-1:0]  i_ROT8,
  input  logic [ROT20_LEN-1:0] i_ROT20_n,
  input  logic                 i_SYS_RUN_FLAG,
  input  logic                 i_CLK2M_STOP_DLYD_n,
  input  logic                 i_FORCE_STOP,
  k005297_subclk_sched_if.slave bus,
  output logic                 o_CLK2M_STOPRQ0_n,
  output logic                 o_CLK2M_STOPRQ1_n
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  sched_state_t    state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] mask;
  logic [HW-1:0]   hold_cnt;

  logic            tick;
  logic            slot;
  logic            req_win;
  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  assign tick       = ~i_CLK4M_PCEN_n;
  // ROT8[3] keeps the request stable well before the supervisor samples it at ROT8[5].
  assign slot       = ~i_ROT20_n[SLOT_IDX] & i_ROT8[3];
  assign req_win    = bus.req[winner];
  assign win_onehot = NREQ'(1) << winner;

  k005297_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req & ~mask),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // NOTE: all state uses <= so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge i_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state             <= ST_IDLE;
      winner            <= '0;
      rr_ptr            <= IW'(NREQ - 1);
      mask              <= '0;
      hold_cnt          <= '0;
      bus.gnt           <= '0;
      bus.busy          <= 1'b0;
      bus.timeout       <= 1'b0;
      o_CLK2M_STOPRQ0_n <= 1'b1;
      o_CLK2M_STOPRQ1_n <= 1'b1;
    end else if (tick) begin
      o_CLK2M_STOPRQ1_n <= ~i_FORCE_STOP;
      bus.timeout       <= 1'b0;
      mask              <= mask & bus.req;
      if (!i_SYS_RUN_FLAG) begin
        // Supervisor restarts the subclock on its own; just let go of everything.
        state             <= ST_IDLE;
        bus.gnt           <= '0;
        bus.busy          <= 1'b0;
        o_CLK2M_STOPRQ0_n <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pick_valid && !i_FORCE_STOP) begin
              winner   <= pick_idx;
              bus.busy <= 1'b1;
              state    <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (!req_win) begin
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end else if (slot) begin
              o_CLK2M_STOPRQ0_n <= 1'b0;
              state             <= ST_STOPPING;
            end
          end
          ST_STOPPING: begin
            if (!req_win) begin
              o_CLK2M_STOPRQ0_n <= 1'b1;
              state             <= ST_RELEASE;
            end else if (!i_CLK2M_STOP_DLYD_n) begin
              bus.gnt  <= win_onehot;
              rr_ptr   <= winner;
              hold_cnt <= '0;
              state    <= ST_GRANTED;
            end
          end
          ST_GRANTED: begin
            // A drop on the same tick as expiry wins: no timeout, no mask.
            if (!req_win) begin
              bus.gnt           <= '0;
              o_CLK2M_STOPRQ0_n <= 1'b1;
              state             <= ST_RELEASE;
            end else if (hold_cnt == HOLD_LAST) begin
              bus.gnt           <= '0;
              bus.timeout       <= 1'b1;
              mask              <= (mask & bus.req) | win_onehot;
              o_CLK2M_STOPRQ0_n <= 1'b1;
              state             <= ST_RELEASE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            o_CLK2M_STOPRQ0_n <= 1'b1;
            if (i_CLK2M_STOP_DLYD_n) begin
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
